// File: rtl/irq_seq_pkg.sv
// Shared types and constants for the interrupt service sequencer.
package irq_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        PRESENT = 3'd2,
        REQ_BUS = 3'd3,
        CLEAR   = 3'd4,
        SETTLE  = 3'd5
    } irq_state_t;

    localparam logic [1:0]  IRQ_STATUS_ADDR = 2'b11;
    localparam int unsigned DEFAULT_NUM_SRC = 8;

    // Index width for a source vector, never narrower than one bit.
    function automatic int unsigned src_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_service_sequencer_rr_pick.sv
// Round-robin first-set finder: scans upward from ptr, wrapping at NUM_SRC-1.
module rr_priority_pick
    import irq_seq_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]              req,
    input  logic [src_idx_w(NUM_SRC)-1:0]   ptr,
    output logic                            found_c,
    output logic [src_idx_w(NUM_SRC)-1:0]   idx_c
);

    localparam int unsigned IDX_W = src_idx_w(NUM_SRC);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= NUM_SRC) begin
            s = s - NUM_SRC;
        end
        return IDX_W'(s);
    endfunction

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found_c && req[wrap_add(ptr, i)]) begin
                found_c = 1'b1;
                idx_c   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/irq_service_sequencer.sv
// Presents one pending interrupt vector at a time to the CPU and issues the
// write-1-to-clear to the status register once acknowledged or timed out.
module irq_service_sequencer
    import irq_seq_pkg::*;
#(
    parameter int unsigned DATA_REG_BITS = 32,
    parameter int unsigned NUM_SRC       = DEFAULT_NUM_SRC,
    parameter int unsigned ACK_TIMEOUT   = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_REG_BITS-1:0]        status_in,
    input  logic                            irq_in,
    input  logic                            cpu_ack,
    input  logic                            bus_gnt,
    output logic                            vec_valid,
    output logic [src_idx_w(NUM_SRC)-1:0]   vec_id,
    output logic                            bus_req,
    output logic                            clr_wr,
    output logic [1:0]                      clr_address,
    output logic [DATA_REG_BITS-1:0]        clr_data,
    output logic                            timeout_pulse,
    output logic                            busy
);

    localparam int unsigned IDX_W = src_idx_w(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

    irq_state_t               state, state_nxt;
    logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]         vec_id_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     vec_valid_nxt;
    logic                     bus_req_nxt;
    logic                     clr_wr_nxt;
    logic [DATA_REG_BITS-1:0] clr_data_nxt;
    logic                     timeout_pulse_nxt;
    logic                     busy_nxt;

    logic [NUM_SRC-1:0]       req_vec;
    logic                     pick_found;
    logic [IDX_W-1:0]         pick_idx;

    assign req_vec     = status_in[NUM_SRC-1:0];
    assign clr_address = IRQ_STATUS_ADDR;

    generate
        if (DATA_REG_BITS > NUM_SRC) begin : g_unused_status
            logic unused_status_bits;
            assign unused_status_bits = ^status_in[DATA_REG_BITS-1:NUM_SRC];
        end
    endgenerate

    rr_priority_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req     (req_vec),
        .ptr     (rr_ptr),
        .found_c (pick_found),
        .idx_c   (pick_idx)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_nxt         = state;
        rr_ptr_nxt        = rr_ptr;
        vec_id_nxt        = vec_id;
        cnt_nxt           = cnt;
        vec_valid_nxt     = vec_valid;
        clr_wr_nxt        = 1'b0;
        clr_data_nxt      = '0;
        timeout_pulse_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (irq_in && (|req_vec)) begin
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (pick_found) begin
                    vec_id_nxt    = pick_idx;
                    vec_valid_nxt = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = PRESENT;
                end else begin
                    vec_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            PRESENT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cpu_ack) begin
                    vec_valid_nxt = 1'b0;
                    state_nxt     = REQ_BUS;
                end else if (!req_vec[vec_id]) begin
                    vec_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    vec_valid_nxt     = 1'b0;
                    timeout_pulse_nxt = 1'b1;
                    state_nxt         = REQ_BUS;
                end
            end
            REQ_BUS: begin
                vec_valid_nxt = 1'b0;
                if (bus_gnt) begin
                    clr_wr_nxt   = 1'b1;
                    clr_data_nxt = DATA_REG_BITS'(1) << vec_id;
                    state_nxt    = CLEAR;
                end
            end
            CLEAR: begin
                rr_ptr_nxt = (32'(vec_id) == NUM_SRC - 1) ? '0 : vec_id + IDX_W'(1);
                state_nxt  = SETTLE;
            end
            SETTLE: begin
                state_nxt = IDLE;
            end
            default: begin
                vec_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase

        bus_req_nxt = (state_nxt == REQ_BUS) || (state_nxt == CLEAR);
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            vec_valid     <= 1'b0;
            vec_id        <= '0;
            bus_req       <= 1'b0;
            clr_wr        <= 1'b0;
            clr_data      <= '0;
            timeout_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_ptr_nxt;
            cnt           <= cnt_nxt;
            vec_valid     <= vec_valid_nxt;
            vec_id        <= vec_id_nxt;
            bus_req       <= bus_req_nxt;
            clr_wr        <= clr_wr_nxt;
            clr_data      <= clr_data_nxt;
            timeout_pulse <= timeout_pulse_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_irq_service_sequencer.sv
// Self-checking bench for irq_service_sequencer: vector table, randomized
// transactions against a round-robin model, and hand-written corner cases.
module tb_irq_service_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 8;
    localparam int unsigned AT = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] status_in;
    logic          irq_in;
    logic          cpu_ack;
    logic          bus_gnt;
    logic          vec_valid;
    logic [2:0]    vec_id;
    logic          bus_req;
    logic          clr_wr;
    logic [1:0]    clr_address;
    logic [DW-1:0] clr_data;
    logic          timeout_pulse;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int model_ptr = 0;

    irq_service_sequencer #(
        .DATA_REG_BITS (DW),
        .NUM_SRC       (NS),
        .ACK_TIMEOUT   (AT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .status_in     (status_in),
        .irq_in        (irq_in),
        .cpu_ack       (cpu_ack),
        .bus_gnt       (bus_gnt),
        .vec_valid     (vec_valid),
        .vec_id        (vec_id),
        .bus_req       (bus_req),
        .clr_wr        (clr_wr),
        .clr_address   (clr_address),
        .clr_data      (clr_data),
        .timeout_pulse (timeout_pulse),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] st;
        int          ack_dly;   // -1: never acknowledge
        int          gnt_dly;
        int          exp_id;
        logic [31:0] exp_clr;
        logic        exp_pulse;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec_valid"}, vec_valid, 0);
        check({tag, "_vec_id"}, vec_id, 0);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_clr_wr"}, clr_wr, 0);
        check({tag, "_clr_data"}, clr_data, 0);
        check({tag, "_timeout_pulse"}, timeout_pulse, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_clr_address"}, clr_address, 2'b11);
    endtask

    // One full service: raise status, present, ack or time out, grant, clear, settle.
    task automatic run_txn(input logic [31:0] st, input int ack_dly, input int gnt_dly,
                           input int exp_id, input logic [31:0] exp_clr, input logic exp_pulse);
        int n_present;
        status_in = st;
        irq_in    = |st;
        cpu_ack   = 1'b0;
        bus_gnt   = (gnt_dly == 0);
        step();
        step();
        check("vec_valid_rise", vec_valid, 1);
        check("vec_id", vec_id, exp_id);
        n_present = (ack_dly >= 0) ? ack_dly + 1 : int'(AT);
        for (int i = 0; i < n_present; i++) begin
            if (i > 0) check("vec_hold", (vec_valid && vec_id == 3'(exp_id)), 1);
            cpu_ack = (i == ack_dly);
            step();
        end
        cpu_ack = 1'b0;
        check("req_bus", bus_req, 1);
        check("vec_drop", vec_valid, 0);
        check("timeout_pulse", timeout_pulse, exp_pulse);
        check("no_early_clr", clr_wr, 0);
        for (int j = 0; j < gnt_dly; j++) begin
            step();
            check("gnt_wait", {bus_req, clr_wr, timeout_pulse}, 3'b100);
        end
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check("clr_wr", clr_wr, 1);
        check("clr_data", clr_data, exp_clr);
        check("clr_bus_req", bus_req, 1);
        check("clr_pulse_gone", timeout_pulse, 0);
        status_in = '0;
        irq_in    = 1'b0;
        step();
        check("settle", {bus_req, clr_wr, busy}, 3'b001);
        step();
        check("back_idle", busy, 0);
    endtask

    initial begin
        logic [31:0] st;
        int          ack_dly;
        int          gnt_dly;
        int          exp_id;

        rst_n     = 1'b0;
        status_in = '0;
        irq_in    = 1'b0;
        cpu_ack   = 1'b0;
        bus_gnt   = 1'b0;
        step();
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        tbl[0] = '{32'h0000_0081,  0,  0, 0, 32'h01, 1'b0};
        tbl[1] = '{32'h0000_0081,  1,  0, 7, 32'h80, 1'b0};
        tbl[2] = '{32'h0000_0081,  2,  1, 0, 32'h01, 1'b0};
        tbl[3] = '{32'h0000_0081,  0,  0, 7, 32'h80, 1'b0};
        tbl[4] = '{32'h0000_0004,  0,  0, 2, 32'h04, 1'b0};
        tbl[5] = '{32'h0000_0010, -1,  0, 4, 32'h10, 1'b1};
        tbl[6] = '{32'h0000_0010,  3,  0, 4, 32'h10, 1'b0};
        tbl[7] = '{32'h0000_0021,  1,  2, 5, 32'h20, 1'b0};
        tbl[8] = '{32'h0000_0003,  0, 10, 0, 32'h01, 1'b0};
        tbl[9] = '{32'hFF00_0003,  2,  0, 1, 32'h02, 1'b0};
        for (int k = 0; k < 10; k++) begin
            run_txn(tbl[k].st, tbl[k].ack_dly, tbl[k].gnt_dly,
                    tbl[k].exp_id, tbl[k].exp_clr, tbl[k].exp_pulse);
        end
        model_ptr = 2;

        // Randomized services against a round-robin model.
        for (int n = 0; n < 40; n++) begin
            st      = $urandom();
            st[7:0] = 8'($urandom_range(255, 1));
            ack_dly = int'($urandom_range(4, 0)) - 1;
            gnt_dly = int'($urandom_range(3, 0));
            exp_id  = -1;
            for (int k = 0; k < int'(NS); k++) begin
                if (exp_id < 0 && st[(model_ptr + k) % NS]) exp_id = (model_ptr + k) % NS;
            end
            run_txn(st, ack_dly, gnt_dly, exp_id, 32'(1) << exp_id, ack_dly < 0);
            model_ptr = (exp_id + 1) % NS;
        end

        // Only unused status bits set, plus an ack outside PRESENT: stay idle.
        status_in = 32'h0000_0100;
        irq_in    = 1'b1;
        cpu_ack   = 1'b1;
        step(); step(); step();
        check("unused_bits_idle", {busy, vec_valid}, 2'b00);
        cpu_ack   = 1'b0;
        status_in = '0;
        irq_in    = 1'b0;

        // Status vanishes during SELECT: return to idle without a vector.
        status_in = 32'h02;
        irq_in    = 1'b1;
        step();
        check("select_busy", busy, 1);
        status_in = '0;
        irq_in    = 1'b0;
        step();
        check("select_abort", {busy, vec_valid}, 2'b00);

        // Source masked during PRESENT: drop the vector, no clear.
        status_in = 32'h10;
        irq_in    = 1'b1;
        step(); step();
        check("mask_present", (vec_valid && vec_id == 3'd4), 1);
        status_in = '0;
        irq_in    = 1'b0;
        step();
        check("mask_drop", {vec_valid, busy, bus_req, clr_wr}, 4'b0000);
        step();
        check("mask_no_clr", {clr_wr, bus_req}, 2'b00);

        // Async reset while waiting for the bus aborts everything.
        status_in = 32'h01;
        irq_in    = 1'b1;
        bus_gnt   = 1'b0;
        step(); step();
        check("rst_pre_vec", (vec_valid && vec_id == 3'd0), 1);
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        check("rst_pre_req", bus_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        bus_gnt = 1'b1;
        @(negedge clk);
        check("rst_no_clr", clr_wr, 0);
        bus_gnt = 1'b0;
        rst_n   = 1'b1;
        step(); step();
        check("rst_repick", (vec_valid && vec_id == 3'd0), 1);
        status_in = '0;
        irq_in    = 1'b0;
        step();
        check("rst_final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_service_sequencer.md
Name: irq_service_sequencer

Overview:
- Sits between the UART interrupt status register block and the host CPU.
- Picks one pending, unmasked interrupt source at a time using round-robin order and presents its vector to the CPU.
- Waits for the CPU acknowledge, then acquires the register bus and issues the write-1-to-clear to the status register at address 2'b11.
- An acknowledge timeout stops a silent CPU from blocking service forever.

Parameters:
- DATA_REG_BITS, 32, width of the register data bus and status word.
- NUM_SRC, 8, number of interrupt sources; only status bits [NUM_SRC-1:0] are used.
- ACK_TIMEOUT, 1024, cycles in PRESENT before a forced clear; must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- status_in  in  DATA_REG_BITS  interrupt status word from the status register block; bits ≥ NUM_SRC are ignored.
- irq_in  in  1  OR of the status bits.
- cpu_ack  in  1  CPU acknowledge of the presented vector; one-cycle pulse or level.
- bus_gnt  in  1  register-bus grant from the host bus arbiter.
- vec_valid  out  1  a vector is being presented.
- vec_id  out  $clog2(NUM_SRC)  index of the presented source.
- bus_req  out  1  request for the register bus.
- clr_wr  out  1  one-cycle write strobe to the status register.
- clr_address  out  2  write address; constant 2'b11.
- clr_data  out  DATA_REG_BITS  one-hot clear mask; upper bits are 0.
- timeout_pulse  out  1  one-cycle pulse when a vector is force-cleared.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0 (clr_address is the constant 2'b11). State = IDLE, rr_ptr = 0, timeout counter = 0.
- IDLE:
  - If irq_in and |status_in[NUM_SRC-1:0], go to SELECT next edge.
  - irq_in high with all used bits 0 stays in IDLE.
- SELECT (1 cycle):
  - Winner is the first set bit at or after rr_ptr, scanning upward and wrapping NUM_SRC-1→0.
  - Register vec_id ← winner, vec_valid ← 1, counter ← 0, then go to PRESENT.
  - If no bit is set any more, return to IDLE with vec_valid = 0.
- PRESENT:
  - vec_valid = 1 and vec_id stays stable. The counter increments every cycle.
  - Priority order, highest first:
    - cpu_ack → REQ_BUS.
    - status_in[vec_id] = 0 (source masked or cleared externally) → vec_valid ← 0, go to IDLE, no clear, rr_ptr unchanged.
    - counter = ACK_TIMEOUT-1 → timeout_pulse ← 1 for one cycle, then REQ_BUS.
  - When ack and timeout occur in the same cycle, ack wins and no pulse is issued.
- REQ_BUS:
  - bus_req = 1 and vec_valid ← 0. Wait indefinitely for bus_gnt.
  - If bus_gnt is already high on entry, the transition happens on the next edge.
- CLEAR (1 cycle):
  - clr_wr = 1 and clr_data = 1 << vec_id. bus_req stays 1.
  - rr_ptr ← vec_id+1, wrapping to 0 at NUM_SRC.
  - Go to SETTLE.
- SETTLE (1 cycle):
  - bus_req = 0.
  - This cycle lets the status register absorb the clear, so the stale bit cannot be re-picked.
  - Go to IDLE.
- cpu_ack outside PRESENT is ignored.
- A source re-asserting after its clear is serviced again in its round-robin turn.
- Latency:
  - status bit set at cycle t (irq_in high at t) → vec_valid high at t+2.
  - ack at cycle a → clr_wr at a+2 with bus_gnt held high; then 1 more cycle before IDLE.
- Reset mid-operation aborts everything immediately; no partial clear is issued.

Decomposition:
- Package irq_seq_pkg holds:
  - state enum: IDLE, SELECT, PRESENT, REQ_BUS, CLEAR, SETTLE
  - IRQ_STATUS_ADDR = 2'b11
  - default NUM_SRC
  - SRC_IDX_W function
- Sub-module rr_priority_pick: combinational round-robin first-set finder. Inputs: request vector and pointer. Outputs: found flag and index.

Test Plan:
- Single source: status=8'h04 → vec_valid at t+2 with vec_id=2. Ack with bus_gnt=1 → clr_wr=1 and clr_data=32'h4 two cycles later, rr_ptr=3.
- Round-robin: status=8'h81 held, each vector acked → vec_id sequence 0,7,0,7. Each clr_data is one-hot and matches the vector.
- Mask drop: status=8'h10, then bit 4 cleared during PRESENT → vec_valid drops next cycle, no clr_wr, busy=0 within 1 cycle.
- Timeout: ACK_TIMEOUT=4, no ack → timeout_pulse exactly 1 cycle after 4 PRESENT cycles, followed by clr_wr with clr_data=32'h10. Repeat with ack on the timeout cycle → no pulse.
- Bus contention: ack given with bus_gnt=0 for 10 cycles → bus_req held high and no clr_wr. Grant given → clr_wr exactly one cycle later.
- Async reset asserted in REQ_BUS → all outputs 0 immediately. After release, a pending status=8'h01 is re-presented with vec_id=0.
